// File: rtl/serializer_20b.sv
// serializer_20b: 20-bit parallel-to-serial stage with a one-word holding register, MSB first.
//
// Ports:
//   clk      - single clock, rising edge
//   rst      - synchronous active-low reset
//   ena      - Din valid; word taken on an edge with ena && rdy
//   Din      - W-bit encoded word, bit W-1 sent first
//   rdy      - holding register empty (combinational, low during reset)
//   Dout     - serial bit (registered)
//   Dout_vld - Dout carries a data or idle bit
//   sof      - first (MSB) bit of each shifted word
//   idle     - current word is IDLE_WORD fill
//   drop     - one-cycle pulse when ena arrives while rdy is low; that word is lost
//
// Optional feature: define SER_IDLE_FILL_EN to fill underruns with IDLE_WORD
// instead of letting the line go invalid.
module serializer_20b #(
    parameter int             W         = 20,
    parameter logic [W-1:0]   IDLE_WORD = 20'h3EB05
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic [W-1:0] Din,
    output logic         rdy,
    output logic         Dout,
    output logic         Dout_vld,
    output logic         sof,
    output logic         idle,
    output logic         drop
);
    localparam int             CW   = $clog2(W);
    localparam logic [CW-1:0]  LAST = CW'(W - 1);

    logic [W-1:0]  hold_q, hold_d, sh_q, sh_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          hold_vld_q, hold_vld_d, busy_q, busy_d, idle_q, idle_d;
    logic          dout_q, dout_d, vld_q, vld_d, sof_q, sof_d, drop_q, drop_d;
    logic          load_pt;

    assign rdy      = !hold_vld_q && rst;
    assign load_pt  = !busy_q || cnt_q == LAST;
    assign Dout     = dout_q;
    assign Dout_vld = vld_q;
    assign sof      = sof_q;
    assign idle     = idle_q;
    assign drop     = drop_q;

    always_comb begin
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        sh_d       = sh_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        idle_d     = idle_q;
        // accept and load-from-hold are mutually exclusive: one needs hold empty, the other full
        if (ena && rdy) begin
            hold_d     = Din;
            hold_vld_d = 1'b1;
        end
        if (load_pt && hold_vld_q) begin
            sh_d       = hold_q;
            hold_vld_d = 1'b0;
            cnt_d      = '0;
            busy_d     = 1'b1;
            idle_d     = 1'b0;
        end else if (load_pt) begin
`ifdef SER_IDLE_FILL_EN
            sh_d   = IDLE_WORD;
            cnt_d  = '0;
            busy_d = 1'b1;
            idle_d = 1'b1;
`else
            // final shift empties sh so Dout reads 0 while the line is invalid
            sh_d   = sh_q << 1;
            busy_d = 1'b0;
            idle_d = 1'b0;
`endif
        end else begin
            sh_d  = sh_q << 1;
            cnt_d = cnt_q + CW'(1);
        end
        dout_d = sh_d[W-1];
        vld_d  = busy_d;
        sof_d  = busy_d && cnt_d == '0;
        drop_d = ena && !rdy && rst;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            sh_q       <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            idle_q     <= 1'b0;
            dout_q     <= 1'b0;
            vld_q      <= 1'b0;
            sof_q      <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            sh_q       <= sh_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            idle_q     <= idle_d;
            dout_q     <= dout_d;
            vld_q      <= vld_d;
            sof_q      <= sof_d;
            drop_q     <= drop_d;
        end
    end
endmodule
